// File: rtl/slt_arbiter_pkg.sv
// Shared encodings for the set-less-than arbiter and its comparator.
// Pure definitions; no logic, no latency.
package slt_arbiter_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic ALUC_UNSIGNED = 1'b0;
    localparam logic ALUC_SIGNED   = 1'b1;
endpackage

// File: rtl/slt_32bits.sv
// 32-bit set-less-than / equality comparator, signed or unsigned by aluc.
// Purely combinational (0 cycles); no backpressure.
module slt_32bits
    import slt_arbiter_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        aluc,
    output logic [31:0] r,
    output logic        equal,
    output logic        smaller
);
    // Differing signs decide a signed compare outright; with equal signs the
    // two's-complement order matches the unsigned order.
    assign smaller = (aluc == ALUC_SIGNED && a[31] != b[31]) ? a[31] : (a < b);
    assign equal   = (a == b);
    assign r       = {31'b0, smaller};
endmodule

// File: rtl/slt_arbiter.sv
// Round-robin shares one slt_32bits between N_REQ requesters; registered operands and result.
// Latency: grant cycle -> rsp_valid 2 cycles later; initiation interval 3 with rsp_ack high.
// Backpressure: rsp_* held until rsp_ack; no grant issued outside IDLE.
module slt_arbiter
    import slt_arbiter_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 32,
    parameter int ID_W   = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    input  logic [N_REQ-1:0]        req_signed,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [DATA_W-1:0]       rsp_r,
    output logic                    rsp_equal,
    output logic                    rsp_smaller,
    input  logic                    rsp_ack,
    output logic                    busy
);
    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   id_q;
    logic [ID_W-1:0]   win_idx;
    logic [N_REQ-1:0]  win_oh;
    logic              found;
    logic [DATA_W-1:0] a_q, b_q, a_sel, b_sel;
    logic              sgn_q, sgn_sel;
    logic [DATA_W-1:0] cmp_r;
    logic              cmp_eq, cmp_sm;
    logic [ID_W-1:0]   rr_nxt;

    // Two passes give the wrap-around search: first rr_ptr..N_REQ-1, then 0..rr_ptr-1.
    always_comb begin
        found   = 1'b0;
        win_oh  = '0;
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_valid[i] && ID_W'(i) >= rr_ptr) begin
                found     = 1'b1;
                win_oh[i] = 1'b1;
                win_idx   = ID_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_valid[i]) begin
                found     = 1'b1;
                win_oh[i] = 1'b1;
                win_idx   = ID_W'(i);
            end
        end
    end

    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        sgn_sel = ALUC_UNSIGNED;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_oh[i]) begin
                a_sel   = req_a[i*DATA_W +: DATA_W];
                b_sel   = req_b[i*DATA_W +: DATA_W];
                sgn_sel = req_signed[i];
            end
        end
    end

    assign req_ready = (state == ST_IDLE) ? win_oh : '0;
    assign busy      = (state != ST_IDLE);
    assign rr_nxt    = (rsp_id == ID_W'(N_REQ - 1)) ? '0 : rsp_id + ID_W'(1);

    slt_32bits u_cmp (
        .a       (a_q),
        .b       (b_q),
        .aluc    (sgn_q),
        .r       (cmp_r),
        .equal   (cmp_eq),
        .smaller (cmp_sm)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sgn_q       <= ALUC_UNSIGNED;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_r       <= '0;
            rsp_equal   <= 1'b0;
            rsp_smaller <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        a_q   <= a_sel;
                        b_q   <= b_sel;
                        sgn_q <= sgn_sel;
                        id_q  <= win_idx;
                        state <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    rsp_r       <= cmp_r;
                    rsp_equal   <= cmp_eq;
                    rsp_smaller <= cmp_sm;
                    rsp_id      <= id_q;
                    rsp_valid   <= 1'b1;
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    // Pointer moves only on completion so a stalled result keeps its priority slot.
                    if (rsp_ack) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= rr_nxt;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_slt_arbiter.sv
// Scoreboard bench for slt_arbiter: directed requests push expected results,
// a negedge monitor checks grant latency, hold stability and each acked result.
module tb_slt_arbiter;
    localparam int N_REQ  = 2;
    localparam int DATA_W = 32;
    localparam int ID_W   = 3;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*DATA_W-1:0] req_a;
    logic [N_REQ*DATA_W-1:0] req_b;
    logic [N_REQ-1:0]        req_signed;
    logic                    rsp_valid;
    logic [ID_W-1:0]         rsp_id;
    logic [DATA_W-1:0]       rsp_r;
    logic                    rsp_equal;
    logic                    rsp_smaller;
    logic                    rsp_ack;
    logic                    busy;

    slt_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_signed  (req_signed),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_r       (rsp_r),
        .rsp_equal   (rsp_equal),
        .rsp_smaller (rsp_smaller),
        .rsp_ack     (rsp_ack),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ID_W-1:0] id;
        logic            sm;
        logic            eq;
    } exp_t;

    exp_t exp_q[$];
    int   gcyc_q[$];
    int   gid_q[$];
    int   cycle = 0;
    int   vec = 0;
    int   bad = 0;

    logic              was_vld = 1'b0;
    logic [ID_W-1:0]   h_id;
    logic [DATA_W-1:0] h_r;
    logic              h_eq, h_sm;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic push_exp(input int id, input logic sm, input logic eq);
        exp_t e;
        e.id = ID_W'(id);
        e.sm = sm;
        e.eq = eq;
        exp_q.push_back(e);
    endtask

    task automatic set_op(input int idx, input logic [31:0] a, input logic [31:0] b, input logic s);
        req_a[idx*DATA_W +: DATA_W] = a;
        req_b[idx*DATA_W +: DATA_W] = b;
        req_signed[idx] = s;
    endtask

    // Monitor: grants, response rise latency, hold stability, handshake compare.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            gcyc_q.delete();
            gid_q.delete();
            was_vld = 1'b0;
        end else begin
            if (req_ready != '0) begin
                int gi;
                gi = 0;
                for (int i = 0; i < N_REQ; i++) if (req_ready[i]) gi = i;
                gcyc_q.push_back(cycle);
                gid_q.push_back(gi);
            end
            if (rsp_valid && !was_vld) begin
                if (gcyc_q.size() == 0) begin
                    chk("rsp_without_grant", 32'd1, 32'd0);
                end else begin
                    chk("grant_to_valid_latency", 32'(cycle - gcyc_q.pop_front()), 32'd2);
                    chk("rsp_id_vs_grant", 32'(rsp_id), 32'(gid_q.pop_front()));
                end
                h_id = rsp_id; h_r = rsp_r; h_eq = rsp_equal; h_sm = rsp_smaller;
            end else if (rsp_valid) begin
                chk("hold_stable", {rsp_id, rsp_r[0], rsp_equal, rsp_smaller},
                    {h_id, h_r[0], h_eq, h_sm});
                chk("hold_r_upper", rsp_r, h_r);
            end
            if (rsp_valid) begin
                chk("rdy_low_in_resp", 32'(req_ready), 32'd0);
                chk("busy_in_resp", 32'(busy), 32'd1);
            end
            if (rsp_valid && rsp_ack) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_smaller", 32'(rsp_smaller), 32'(e.sm));
                    chk("rsp_equal", 32'(rsp_equal), 32'(e.eq));
                    chk("rsp_r", rsp_r, {31'b0, e.sm});
                end
                was_vld = 1'b0;
            end else begin
                was_vld = rsp_valid;
            end
        end
    end

    // Raise req_valid=mask and wait for ngr grants; without hold, granted bits drop after acceptance.
    task automatic run(input logic [N_REQ-1:0] mask, input int ngr, input bit hold);
        int got = 0;
        int guard = 0;
        @(posedge clk); #1;
        req_valid = mask;
        while (got < ngr && guard < 200) begin
            @(negedge clk);
            guard++;
            if (req_ready != '0) begin
                logic [N_REQ-1:0] g;
                g = req_ready;
                got++;
                @(posedge clk); #1;
                if (!hold) req_valid = req_valid & ~g;
            end
        end
        if (got < ngr) chk("grant_timeout", 32'(got), 32'(ngr));
        req_valid = '0;
    endtask

    task automatic wait_vld();
        int guard = 0;
        @(negedge clk);
        while (!rsp_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!rsp_valid) chk("wait_vld_timeout", 32'(rsp_valid), 32'd1);
    endtask

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (busy || exp_q.size() != 0) chk("idle_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
        chk({tag, "_rsp_r"}, rsp_r, 32'd0);
        chk({tag, "_rsp_eq_sm"}, {30'b0, rsp_equal, rsp_smaller}, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        req_signed = '0;
        rsp_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset while a result is waiting in RESP: dropped, never reappears.
        set_op(0, 32'h0000_0005, 32'h0000_0006, 1'b0);
        run(2'b01, 1, 1'b0);
        wait_vld();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("midresp_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_reset_no_rsp", 32'(rsp_valid), 32'd0);
            chk("post_reset_idle", 32'(busy), 32'd0);
        end

        // Single unsigned request.
        push_exp(0, 1'b1, 1'b0);
        set_op(0, 32'h0000_0005, 32'hFFFF_FFFF, 1'b0);
        run(2'b01, 1, 1'b0);
        wait_idle();

        // Signed vs unsigned on requester 1.
        push_exp(1, 1'b1, 1'b0);
        set_op(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        run(2'b10, 1, 1'b0);
        wait_idle();
        push_exp(1, 1'b0, 1'b0);
        set_op(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run(2'b10, 1, 1'b0);
        wait_idle();
        push_exp(1, 1'b0, 1'b1);
        set_op(1, 32'h8000_0000, 32'h8000_0000, 1'b1);
        run(2'b10, 1, 1'b0);
        wait_idle();
        push_exp(1, 1'b0, 1'b0);
        set_op(1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
        run(2'b10, 1, 1'b0);
        wait_idle();
        push_exp(1, 1'b1, 1'b0);
        set_op(1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
        run(2'b10, 1, 1'b0);
        wait_idle();

        // Contention, both held valid, ack high: grants alternate 0,1,0,1.
        set_op(0, 32'd10, 32'd20, 1'b0);
        set_op(1, 32'd7, 32'd7, 1'b1);
        push_exp(0, 1'b1, 1'b0);
        push_exp(1, 1'b0, 1'b1);
        push_exp(0, 1'b1, 1'b0);
        push_exp(1, 1'b0, 1'b1);
        run(2'b11, 4, 1'b1);
        wait_idle();

        // Backpressure with a withdrawn request from requester 1 during RESP.
        rsp_ack = 1'b0;
        push_exp(0, 1'b1, 1'b0);
        set_op(0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        set_op(1, 32'd1, 32'd2, 1'b0);
        run(2'b01, 1, 1'b0);
        wait_vld();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (k == 2) req_valid = 2'b10;
            if (k == 3) req_valid = 2'b00;
            @(negedge clk);
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        end
        @(posedge clk); #1;
        rsp_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("ack_to_idle", 32'(busy), 32'd0);
        chk("withdrawn_not_granted", 32'(req_ready), 32'd0);
        chk("no_pending_grant", 32'(gcyc_q.size()), 32'd0);

        // Pointer advanced past 0: with both valid, requester 1 wins first.
        set_op(1, 32'd3, 32'd2, 1'b0);
        set_op(0, 32'd0, 32'd1, 1'b0);
        push_exp(1, 1'b0, 1'b0);
        push_exp(0, 1'b1, 1'b0);
        run(2'b11, 2, 1'b0);
        wait_idle();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $fatal(1, "watchdog");
    end
endmodule
